instr_queue_decode: RTL and testbench
=====================================

Name: instr_queue_decode

Overview:
Parametrised instruction register for the processor front end. It replaces the single-entry fetch latch with a DEPTH-entry FIFO between instruction memory and the decode/execute stage, with valid/ready handshakes on both sides. It decodes the head entry into opcode, rdest, immediate, opcodeex and rsrc, plus an extended immediate and an R-type flag. Flush support discards prefetched instructions on branch or jump.

Parameters:
WIDTH, 16, instruction width; must be >= 16; field layout anchored at the MSB.
DEPTH, 4, FIFO entries; power of 2, >= 2.
RTYPE_OP, 4'b0000, opcode value that marks a register-register (extended-opcode) instruction.

Ports:
clk  in  1  system clock; all state updates on the rising edge.
reset  in  1  synchronous, active-high reset.
flush  in  1  discard all queued entries; synchronous.
in_valid  in  1  instruction memory presents a word.
in_ready  out  1  queue accepts a word this cycle.
instruction  in  WIDTH  instruction word from instruction memory.
out_valid  out  1  head entry is valid.
out_ready  in  1  decode stage consumes the head this cycle.
opcode  out  4  instruction[WIDTH-1:WIDTH-4] of the head.
rdest  out  4  instruction[WIDTH-5:WIDTH-8] of the head.
immediate  out  WIDTH-8  instruction[WIDTH-9:0] of the head.
opcodeex  out  4  immediate[7:4].
rsrc  out  4  immediate[3:0].
imm_ext  out  WIDTH  immediate[7:0] extended to WIDTH bits (see Optional Feature).
rtype  out  1  opcode == RTYPE_OP.
count  out  $clog2(DEPTH)+1  number of occupied entries, 0..DEPTH.

Behaviour:
- Reset (reset=1 at a clock edge): count=0, read and write pointers=0, out_valid=0, all decoded outputs=0. in_ready=0 while reset is high.
- in_ready = (count < DEPTH) && !reset. This is combinational from registered state; it does not depend on out_ready, so there is no bypass when the queue is full.
- Push: when in_valid && in_ready && !flush, store instruction at wptr and set wptr <= wptr+1, wrapping modulo DEPTH.
- Pop: when out_valid && out_ready && !flush, set rptr <= rptr+1, wrapping modulo DEPTH.
- Push and pop in the same cycle: count is unchanged and both pointers advance.
- Pop is ignored when empty. Push is ignored when full. Neither case corrupts state.
- Latency: a word accepted at edge N appears on the outputs after edge N when the queue was empty (one-cycle fill latency). There is no combinational path from instruction to any output.
- out_valid = (count != 0).
- Decoded fields are a combinational decode of mem[rptr], gated to 0 when out_valid=0.
- Stability: while out_valid && !out_ready, every output holds its value across cycles, even when pushes occur.
- Flush: takes priority over push and pop in the same cycle. At the next edge count=0 and rptr=wptr=0; a word offered that cycle is dropped. in_ready remains 1 during flush, so the source must treat the word as discarded.
- Reset mid-operation behaves like flush and also zeroes the outputs. Stored data contents are don't-care.
- count never exceeds DEPTH or underflows. The bench asserts this invariant.

Optional Feature:
Macro INSTQ_SIGN_EXT_EN.
- Defined: imm_ext = {{(WIDTH-8){immediate[7]}}, immediate[7:0]} (sign-extended, for ADDI/CMPI/branch displacement).
- Undefined: imm_ext = {{(WIDTH-8){1'b0}}, immediate[7:0]} (zero-extended).
- Port list is identical in both builds; when out_valid=0, imm_ext=0 in both.

Test Plan:
1. Reset then push 16'h5A3C with out_ready=0 -> after one edge: out_valid=1, opcode=4'h5, rdest=4'hA, immediate=8'h3C, count=1, rtype=0.
2. Push 16'h0152 (R-type) -> opcode=0, rtype=1, opcodeex=4'h5, rsrc=4'h2, rdest=4'h1.
3. With out_ready=0, push DEPTH=4 words 16'h1001..16'h1004 -> count=4, in_ready=0; a fifth word 16'hFFFF is dropped. Then set out_ready=1 -> words pop in order 1001, 1002, 1003, 1004, then out_valid=0.
4. Queue at count=2; in_valid=1 and out_ready=1 together for 6 cycles -> count stays 2, order preserved across pointer wrap.
5. Queue at count=3; assert flush alongside in_valid=1 (word 16'h2222) -> next edge: count=0, out_valid=0, 16'h2222 never emitted. A later push re-fills from pointer 0.
6. Head immediate=8'hF0, WIDTH=16 -> imm_ext=16'hFFF0 with INSTQ_SIGN_EXT_EN, 16'h00F0 without. A reset asserted mid-stream zeroes all outputs at the next edge.

Source files
------------

// File: rtl/instr_queue_decode_if.sv
// Handshake bundle between instruction memory, the instruction queue and decode.
// Both sides: a transfer happens on an edge where valid && ready; once valid is up the payload holds until ready.
interface instr_queue_decode_if #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
);
    logic                     flush;
    logic                     in_valid;
    logic                     in_ready;
    logic [WIDTH-1:0]         instruction;
    logic                     out_valid;
    logic                     out_ready;
    logic [3:0]               opcode;
    logic [3:0]               rdest;
    logic [WIDTH-9:0]         immediate;
    logic [3:0]               opcodeex;
    logic [3:0]               rsrc;
    logic [WIDTH-1:0]         imm_ext;
    logic                     rtype;
    logic [$clog2(DEPTH):0]   count;

    modport slave (
        input  flush, in_valid, instruction, out_ready,
        output in_ready, out_valid, opcode, rdest, immediate,
               opcodeex, rsrc, imm_ext, rtype, count
    );

    modport master (
        output flush, in_valid, instruction, out_ready,
        input  in_ready, out_valid, opcode, rdest, immediate,
               opcodeex, rsrc, imm_ext, rtype, count
    );
endinterface

// File: rtl/instr_queue_decode.sv
// DEPTH-entry instruction FIFO with head decode and flush.
// Define INSTQ_SIGN_EXT_EN to sign-extend imm_ext; otherwise it is zero-extended.
module instr_queue_decode #(
    parameter int         WIDTH    = 16,
    parameter int         DEPTH    = 4,
    parameter logic [3:0] RTYPE_OP = 4'b0000
) (
    input logic               clk,
    input logic               reset,
    instr_queue_decode_if.slave q
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [CW-1:0]    cnt;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] head;
    logic             valid;

    // in_ready looks only at occupancy, so a full queue never accepts even while popping.
    assign q.in_ready = (cnt < CW'(DEPTH)) && !reset;
    assign valid      = (cnt != '0);
    assign push       = q.in_valid && q.in_ready && !q.flush;
    assign pop        = valid && q.out_ready && !q.flush;

    always_ff @(posedge clk) begin
        if (reset || q.flush) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            if (push && !pop)      cnt <= cnt + 1'b1;
            else if (pop && !push) cnt <= cnt - 1'b1;
        end
    end

    // Storage needs no reset: nothing is read while the queue is empty.
    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= q.instruction;
    end

    assign head = valid ? mem[rptr] : '0;

    assign q.out_valid = valid;
    assign q.count     = cnt;
    assign q.opcode    = head[WIDTH-1 -: 4];
    assign q.rdest     = head[WIDTH-5 -: 4];
    assign q.immediate = head[WIDTH-9:0];
    assign q.opcodeex  = head[7:4];
    assign q.rsrc      = head[3:0];
    assign q.rtype     = valid && (head[WIDTH-1 -: 4] == RTYPE_OP);
`ifdef INSTQ_SIGN_EXT_EN
    assign q.imm_ext   = {{(WIDTH-8){head[7]}}, head[7:0]};
`else
    assign q.imm_ext   = {{(WIDTH-8){1'b0}}, head[7:0]};
`endif
endmodule

// File: tb/tb_instr_queue_decode.sv
// Bench for instr_queue_decode: directed vector table, reset/flush sequences,
// and a random phase checked against a reference queue.
module tb_instr_queue_decode;
  localparam int WIDTH = 16;
  localparam int DEPTH = 4;
  localparam int CW    = 3;
  localparam int NVEC  = 25;

  typedef struct {
    logic        iv;
    logic [15:0] w;
    logic        ordy;
    logic        fl;
    logic [2:0]  ecnt;
    logic [15:0] ehead;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;
  logic [WIDTH-1:0] exp_q[$];
  vec_t tbl[NVEC];

  always #5 clk = ~clk;

  instr_queue_decode_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) q ();

  instr_queue_decode #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RTYPE_OP(4'b0000)) dut (
    .clk(clk),
    .reset(reset),
    .q(q)
  );

  always @(negedge clk)
    assert (q.count <= CW'(DEPTH))
    else $error("FAIL count_bound count=%0d max=%0d", q.count, DEPTH);

  function automatic vec_t mk(logic iv, logic [15:0] w, logic ordy, logic fl,
                              logic [2:0] ecnt, logic [15:0] ehead);
    vec_t v;
    v.iv = iv; v.w = w; v.ordy = ordy; v.fl = fl; v.ecnt = ecnt; v.ehead = ehead;
    return v;
  endfunction

  function automatic logic [15:0] ext(logic [15:0] w);
`ifdef INSTQ_SIGN_EXT_EN
    return {{8{w[7]}}, w[7:0]};
`else
    return {8'h00, w[7:0]};
`endif
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic check_outputs(string tag, logic v, logic [15:0] w);
    logic [15:0] e;
    e = v ? w : 16'h0;
    chk({tag, ".out_valid"}, 32'(q.out_valid), 32'(v));
    chk({tag, ".opcode"},    32'(q.opcode),    32'(e[15:12]));
    chk({tag, ".rdest"},     32'(q.rdest),     32'(e[11:8]));
    chk({tag, ".immediate"}, 32'(q.immediate), 32'(e[7:0]));
    chk({tag, ".opcodeex"},  32'(q.opcodeex),  32'(e[7:4]));
    chk({tag, ".rsrc"},      32'(q.rsrc),      32'(e[3:0]));
    chk({tag, ".imm_ext"},   32'(q.imm_ext),   32'(ext(e)));
    chk({tag, ".rtype"},     32'(q.rtype),     32'(v && (e[15:12] == 4'h0)));
  endtask

  // Drives one cycle; the reference queue predicts occupancy and pop order.
  task automatic cycle(logic iv, logic [15:0] w, logic ordy, logic fl);
    logic        head_v;
    logic [15:0] head_w;
    logic        do_pop;
    logic        do_push;
    logic [15:0] e;
    int          sz;
    q.in_valid    = iv;
    q.instruction = w;
    q.out_ready   = ordy;
    q.flush       = fl;
    #1;
    sz     = exp_q.size();
    head_v = q.out_valid;
    head_w = {q.opcode, q.rdest, q.immediate};
    chk("sb.count",    32'(q.count),    32'(sz));
    chk("sb.in_ready", 32'(q.in_ready), 32'(!reset && (sz < DEPTH)));
    do_pop  = (sz > 0) && ordy && !fl && !reset;
    do_push = iv && (sz < DEPTH) && !fl && !reset;
    @(posedge clk);
    #1;
    if (reset || fl) begin
      exp_q.delete();
    end else begin
      if (do_pop) begin
        e = exp_q.pop_front();
        chk("sb.pop_valid", 32'(head_v), 32'(1));
        chk("sb.pop_word",  32'(head_w), 32'(e));
      end
      if (do_push) exp_q.push_back(w);
    end
  endtask

  initial begin
    // Directed vectors: inputs for one edge, then expected count and head word after it.
    tbl[0]  = mk(1, 16'h5A3C, 0, 0, 1, 16'h5A3C);
    tbl[1]  = mk(1, 16'h0152, 1, 0, 1, 16'h0152);
    tbl[2]  = mk(0, 16'h0000, 1, 0, 0, 16'h0000);
    tbl[3]  = mk(1, 16'h1001, 0, 0, 1, 16'h1001);
    tbl[4]  = mk(1, 16'h1002, 0, 0, 2, 16'h1001);
    tbl[5]  = mk(1, 16'h1003, 0, 0, 3, 16'h1001);
    tbl[6]  = mk(1, 16'h1004, 0, 0, 4, 16'h1001);
    tbl[7]  = mk(1, 16'hFFFF, 0, 0, 4, 16'h1001);
    tbl[8]  = mk(0, 16'h0000, 1, 0, 3, 16'h1002);
    tbl[9]  = mk(0, 16'h0000, 1, 0, 2, 16'h1003);
    tbl[10] = mk(0, 16'h0000, 1, 0, 1, 16'h1004);
    tbl[11] = mk(0, 16'h0000, 1, 0, 0, 16'h0000);
    tbl[12] = mk(1, 16'h3001, 0, 0, 1, 16'h3001);
    tbl[13] = mk(1, 16'h3002, 0, 0, 2, 16'h3001);
    tbl[14] = mk(1, 16'h3003, 1, 0, 2, 16'h3002);
    tbl[15] = mk(1, 16'h3004, 1, 0, 2, 16'h3003);
    tbl[16] = mk(1, 16'h3005, 1, 0, 2, 16'h3004);
    tbl[17] = mk(1, 16'h3006, 1, 0, 2, 16'h3005);
    tbl[18] = mk(1, 16'h3007, 1, 0, 2, 16'h3006);
    tbl[19] = mk(1, 16'h3008, 1, 0, 2, 16'h3007);
    tbl[20] = mk(1, 16'h3009, 0, 0, 3, 16'h3007);
    tbl[21] = mk(1, 16'h2222, 1, 1, 0, 16'h0000);
    tbl[22] = mk(1, 16'h4001, 0, 0, 1, 16'h4001);
    tbl[23] = mk(1, 16'h4AF0, 1, 0, 1, 16'h4AF0);
    tbl[24] = mk(1, 16'h5B7F, 0, 0, 2, 16'h4AF0);

    // Clock/reset
    reset         = 1'b1;
    q.in_valid    = 1'b0;
    q.instruction = '0;
    q.out_ready   = 1'b0;
    q.flush       = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset.count",    32'(q.count),    32'(0));
    chk("reset.in_ready", 32'(q.in_ready), 32'(0));
    check_outputs("reset", 1'b0, 16'h0);
    reset = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      cycle(tbl[i].iv, tbl[i].w, tbl[i].ordy, tbl[i].fl);
      chk($sformatf("vec%0d.count", i),    32'(q.count),    32'(tbl[i].ecnt));
      chk($sformatf("vec%0d.in_ready", i), 32'(q.in_ready), 32'(tbl[i].ecnt < 3'(DEPTH)));
      check_outputs($sformatf("vec%0d", i), tbl[i].ecnt != 3'd0, tbl[i].ehead);
    end

    // Stall with pushes: head must not move.
    cycle(1, 16'h6123, 0, 0);
    check_outputs("stall", 1'b1, 16'h4AF0);
    chk("stall.count", 32'(q.count), 32'(3));

    // Reset mid-stream with a word offered.
    reset = 1'b1;
    cycle(1, 16'h7777, 1, 0);
    chk("midreset.count",    32'(q.count),    32'(0));
    chk("midreset.in_ready", 32'(q.in_ready), 32'(0));
    check_outputs("midreset", 1'b0, 16'h0);
    reset = 1'b0;
    cycle(1, 16'h8F80, 0, 0);
    check_outputs("after_reset", 1'b1, 16'h8F80);

    // Random traffic against the reference queue.
    for (int n = 0; n < 400; n++)
      cycle($urandom_range(0, 3) != 0, 16'($urandom_range(0, 16'hFFFF)),
            $urandom_range(0, 1) == 1, $urandom_range(0, 24) == 0);

    // Drain, bounded.
    for (int n = 0; n < 2 * DEPTH && exp_q.size() != 0; n++)
      cycle(0, 16'h0, 1, 0);
    chk("drain.left", 32'(exp_q.size()), 32'(0));
    chk("drain.count", 32'(q.count), 32'(0));
    check_outputs("drain", 1'b0, 16'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
